// File: rtl/int_to_fp_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// int_to_fp_arbiter_if : request/response bundle for the shared int->fp unit
// Revision 1.0
// ---------------------------------------------------------------------------
interface int_to_fp_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic [31:0]          rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ready;
  logic                 busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/int_to_fp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// int_to_fp_arbiter : round-robin shared int32 -> IEEE-754 single converter,
//                     normalising one bit per clock, truncating the mantissa.
// Revision 1.0
// ---------------------------------------------------------------------------
module int_to_fp_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  int_to_fp_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]     EXP_TOP  = 8'd158;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [31:0]     mag_q, mag_d;
  logic [7:0]      exp_q, exp_d;
  logic            sign_q, sign_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [31:0]     rsp_data_q, rsp_data_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_found;
  logic [NREQ-1:0] req_ready_w;
  logic [31:0]     sel_data;
  logic [31:0]     abs_mag;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  // Scan from the requester after the last winner, wrapping, so the last winner ranks lowest.
  always_comb begin
    grant       = '0;
    grant_id    = last_q;
    grant_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_idx(last_q, k)]) begin
        grant[wrap_idx(last_q, k)] = 1'b1;
        grant_id                   = wrap_idx(last_q, k);
        grant_found                = 1'b1;
      end
    end
  end

  assign sel_data = bus.req_data[32*grant_id +: 32];
  assign abs_mag  = sel_data[31] ? (~sel_data + 32'd1) : sel_data;

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    id_d        = id_q;
    last_d      = last_q;
    rsp_data_d  = rsp_data_q;
    req_ready_w = '0;
    case (state_q)
      IDLE: begin
        req_ready_w = grant;
        if (grant_found) begin
          sign_d = sel_data[31];
          mag_d  = abs_mag;
          exp_d  = EXP_TOP;
          id_d   = grant_id;
          last_d = grant_id;
          if (sel_data == 32'd0) begin
            rsp_data_d = 32'd0;
            state_d    = DONE;
          end else begin
            state_d    = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          rsp_data_d = {sign_q, exp_q, mag_q[30:8]};
          state_d    = DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      id_q       <= '0;
      last_q     <= LAST_RST;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      id_q       <= id_d;
      last_q     <= last_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.req_ready = req_ready_w;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_int_to_fp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_int_to_fp_arbiter : directed bench for the shared int->fp converter
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_int_to_fp_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  int_to_fp_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  int_to_fp_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated request; latency counts clock edges from the accept edge inclusive.
  task automatic do_req(input int idx, input logic [31:0] d, input logic [31:0] exp_data,
                        input int exp_lat, input string tag);
    int cnt;
    @(negedge clk);
    bus.req_valid = '0;
    bus.req_valid[idx] = 1'b1;
    bus.req_data[32*idx +: 32] = d;
    #1 chk({tag, "_ready"}, 32'(bus.req_ready), 32'(4'b0001 << idx));
    @(negedge clk);
    cnt = 1;
    bus.req_valid = '0;
    while (!bus.rsp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
    chk({tag, "_data"}, bus.rsp_data, exp_data);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_idle"}, {31'd0, bus.busy | bus.rsp_valid}, 32'd0);
    bus.rsp_ready = 1'b0;
  endtask

  logic [31:0] exp_rr [4];
  int          cnt;
  int          seen;

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.rsp_ready  = 1'b0;
    exp_rr[0] = 32'h43800000;
    exp_rr[1] = 32'hC3800000;
    exp_rr[2] = 32'h40400000;
    exp_rr[3] = 32'h40A00000;

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;

    // Basic conversions, truncation and zero.
    do_req(0, 32'h00000001, 32'h3F800000, 33, "one");
    do_req(1, 32'hFFFFFFFF, 32'hBF800000, 33, "neg1");
    do_req(1, 32'h80000000, 32'hCF000000, 2,  "minint");
    do_req(2, 32'h7FFFFFFF, 32'h4EFFFFFF, 3,  "maxint");
    do_req(3, 32'h01000001, 32'h4B800000, 9,  "trunc");
    do_req(3, 32'h00000000, 32'h00000000, 1,  "zero");

    // Round robin with all requesters pending.
    @(negedge clk);
    bus.req_data  = {32'h00000005, 32'h00000003, 32'hFFFFFF00, 32'h00000100};
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cnt = 0;
      while (!bus.rsp_valid && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      chk("rr_id", 32'(bus.rsp_id), 32'(n % 4));
      chk("rr_data", bus.rsp_data, exp_rr[n % 4]);
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    do_req(2, 32'h00000003, 32'h40400000, 32, "rr_after");

    // Backpressure in DONE while another requester waits.
    @(negedge clk);
    bus.req_data[127:96] = 32'h80000000;
    bus.req_data[31:0]   = 32'h00000007;
    bus.req_valid        = 4'b1001;
    #1 chk("bp_grant", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    bus.req_valid = 4'b0001;
    chk("bp_norm_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      chk("bp_data", bus.rsp_data, 32'hCF000000);
      chk("bp_id", 32'(bus.rsp_id), 32'd3);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_busy", 32'(bus.busy), 32'd0);
    chk("bp_rel_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_rel_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;

    // Reset in the middle of a normalisation.
    @(negedge clk);
    bus.req_data[63:32] = 32'h00000100;
    bus.req_valid       = 4'b0010;
    #1 chk("mr_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("mr_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_rsp_data", bus.rsp_data, 32'd0);
    chk("mr_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("mr_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("mr_no_rsp", 32'(seen), 32'd0);
    bus.req_valid = 4'b0101;
    #1 chk("mr_next_grant", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    cnt = 1;
    while (!bus.rsp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("mr_lat", 32'(cnt), 32'd31);
    chk("mr_data", bus.rsp_data, 32'h40E00000);
    chk("mr_id", 32'(bus.rsp_id), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
